polar_to_cartesian_pipe: RTL and testbench

POLAR_TO_CARTESIAN_PIPE -- requirements
Module: polar_to_cartesian_pipe

---
 rtl/polar_to_cartesian_pipe.sv | 152 +++++++++++++++
 tb/tb_polar_to_cartesian_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_to_cartesian_pipe.sv
// Three-stage polar-to-Cartesian converter over a 15-degree angle grid.
// Build option: define P2C_ROUND_EN for round-half-up scaling; the default build truncates.
module polar_to_cartesian_pipe #(
  parameter int R_WIDTH     = 8,
  parameter int THETA_WIDTH = 5,
  parameter int FRAC_BITS   = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [R_WIDTH-1:0]        in_r,
  input  logic [THETA_WIDTH-1:0]    in_theta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [R_WIDTH:0]   out_x,
  output logic signed [R_WIDTH:0]   out_y,
  output logic                      out_err
);

  localparam int CW = FRAC_BITS + 1;
  localparam int PW = R_WIDTH + 9;
`ifdef P2C_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1 << (FRAC_BITS - 1));
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  // Quarter-wave magnitudes for 0..90 degrees in 15-degree steps.
  function automatic logic [CW-1:0] lut(input logic [2:0] k);
    case (k)
      3'd0:    lut = CW'(0);
      3'd1:    lut = CW'(66);
      3'd2:    lut = CW'(128);
      3'd3:    lut = CW'(181);
      3'd4:    lut = CW'(222);
      3'd5:    lut = CW'(247);
      3'd6:    lut = CW'(256);
      default: lut = CW'(0);
    endcase
  endfunction

  logic advance;

  logic [31:0]         theta_ext;
  logic                dec_legal;
  logic [1:0]          dec_q;
  logic [2:0]          dec_k;
  logic [CW-1:0]       dec_sin;
  logic [CW-1:0]       dec_cos;
  logic                dec_neg_x;
  logic                dec_neg_y;

  logic                s1_valid;
  logic [R_WIDTH-1:0]  s1_r;
  logic [CW-1:0]       s1_sin;
  logic [CW-1:0]       s1_cos;
  logic                s1_neg_x;
  logic                s1_neg_y;
  logic                s1_err;

  logic                s2_valid;
  logic [PW-1:0]       s2_prod_sin;
  logic [PW-1:0]       s2_prod_cos;
  logic                s2_neg_x;
  logic                s2_neg_y;
  logic                s2_err;

  logic [PW-1:0]       sum_x;
  logic [PW-1:0]       sum_y;
  logic [R_WIDTH:0]    mag_x;
  logic [R_WIDTH:0]    mag_y;
  logic [R_WIDTH:0]    next_x;
  logic [R_WIDTH:0]    next_y;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Illegal indices get zero coefficients so both coordinates come out as exact zero.
  always_comb begin
    theta_ext = 32'(in_theta);
    dec_legal = (theta_ext <= 32'd23);
    dec_q     = 2'(theta_ext / 32'd6);
    dec_k     = 3'(theta_ext % 32'd6);
    dec_sin   = '0;
    dec_cos   = '0;
    dec_neg_x = 1'b0;
    dec_neg_y = 1'b0;
    if (dec_legal) begin
      if (dec_q == 2'd0 || dec_q == 2'd2) begin
        dec_sin = lut(dec_k);
        dec_cos = lut(3'd6 - dec_k);
      end else begin
        dec_sin = lut(3'd6 - dec_k);
        dec_cos = lut(dec_k);
      end
      dec_neg_x = (dec_q == 2'd1) || (dec_q == 2'd2);
      dec_neg_y = (dec_q == 2'd2) || (dec_q == 2'd3);
    end
  end

  always_comb begin
    sum_x  = s2_prod_cos + RND;
    sum_y  = s2_prod_sin + RND;
    mag_x  = (R_WIDTH+1)'(sum_x >> FRAC_BITS);
    mag_y  = (R_WIDTH+1)'(sum_y >> FRAC_BITS);
    next_x = s2_neg_x ? (~mag_x + 1'b1) : mag_x;
    next_y = s2_neg_y ? (~mag_y + 1'b1) : mag_y;
  end

  // Every stage moves together; a stalled output freezes the whole pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_r        <= '0;
      s1_sin      <= '0;
      s1_cos      <= '0;
      s1_neg_x    <= 1'b0;
      s1_neg_y    <= 1'b0;
      s1_err      <= 1'b0;
      s2_valid    <= 1'b0;
      s2_prod_sin <= '0;
      s2_prod_cos <= '0;
      s2_neg_x    <= 1'b0;
      s2_neg_y    <= 1'b0;
      s2_err      <= 1'b0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_err     <= 1'b0;
    end else if (advance) begin
      s1_valid    <= in_valid;
      s1_r        <= in_r;
      s1_sin      <= dec_sin;
      s1_cos      <= dec_cos;
      s1_neg_x    <= dec_neg_x;
      s1_neg_y    <= dec_neg_y;
      s1_err      <= ~dec_legal;
      s2_valid    <= s1_valid;
      s2_prod_sin <= PW'(s1_r) * PW'(s1_sin);
      s2_prod_cos <= PW'(s1_r) * PW'(s1_cos);
      s2_neg_x    <= s1_neg_x;
      s2_neg_y    <= s1_neg_y;
      s2_err      <= s1_err;
      out_valid   <= s2_valid;
      out_x       <= next_x;
      out_y       <= next_y;
      out_err     <= s2_err;
    end
  end

endmodule

// File: tb/tb_polar_to_cartesian_pipe.sv
// Self-checking bench: directed cases plus randomized traffic against a
// degree-based trig reference model with a result queue.
module tb_polar_to_cartesian_pipe;

  localparam int R_WIDTH     = 8;
  localparam int THETA_WIDTH = 5;
`ifdef P2C_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [R_WIDTH-1:0]      in_r = '0;
  logic [THETA_WIDTH-1:0]  in_theta = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [R_WIDTH:0] out_x;
  logic signed [R_WIDTH:0] out_y;
  logic                    out_err;

  typedef struct {
    int x;
    int y;
    int err;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lut[7] = '{0, 66, 128, 181, 222, 247, 256};

  polar_to_cartesian_pipe #(
    .R_WIDTH(R_WIDTH),
    .THETA_WIDTH(THETA_WIDTH),
    .FRAC_BITS(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_r(in_r),
    .in_theta(in_theta),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x(out_x),
    .out_y(out_y),
    .out_err(out_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Signed sine on the 15-degree grid, times 256, built from quarter-wave symmetry.
  function automatic int trig_sin(input int deg);
    int d;
    d = deg % 360;
    if (d <= 90)       return lut[d / 15];
    else if (d <= 180) return lut[(180 - d) / 15];
    else if (d <= 270) return -lut[(d - 180) / 15];
    else               return -lut[(360 - d) / 15];
  endfunction

  function automatic int scale(input int r, input int c);
    if (c < 0) return -((r * (-c) + RND) / 256);
    else       return (r * c + RND) / 256;
  endfunction

  function automatic exp_t model(input int r, input int th);
    exp_t e;
    e.acc = 0;
    if (th > 23) begin
      e.x = 0; e.y = 0; e.err = 1;
    end else begin
      e.x   = scale(r, trig_sin(th * 15 + 90));
      e.y   = scale(r, trig_sin(th * 15));
      e.err = 0;
    end
    return e;
  endfunction

  task automatic check_output(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One clock of traffic: scoreboard the output side, then record any acceptance.
  task automatic apply_stimulus(input bit v, input int r, input int th, input bit rdy,
                                input bit chk_lat, output bit acc);
    exp_t e;
    int   ox;
    int   oy;
    in_valid  = v;
    in_r      = R_WIDTH'(r);
    in_theta  = THETA_WIDTH'(th);
    out_ready = rdy;
    #1;
    acc = in_valid && in_ready;
    ox  = $signed(out_x);
    oy  = $signed(out_y);
    if (out_valid) begin
      check_output("result_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        if (out_ready) begin
          e = exp_q.pop_front();
          check_output("out_x", ox, e.x);
          check_output("out_y", oy, e.y);
          check_output("out_err", int'(out_err), e.err);
          if (chk_lat) check_output("latency", cyc - e.acc, 3);
        end else begin
          check_output("held_x", ox, exp_q[0].x);
          check_output("held_y", oy, exp_q[0].y);
          check_output("held_err", int'(out_err), exp_q[0].err);
        end
      end
    end
    if (acc) begin
      e     = model(r, th);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) apply_stimulus(0, 0, 0, 1, 0, acc);
    check_output("drain_empty", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, acc);
  endtask

  // Single isolated sample with hand-derived expectations and exact-latency checks.
  task automatic directed(input string tag, input int r, input int th,
                          input int ex, input int ey, input int eerr);
    in_valid  = 1'b1;
    in_r      = R_WIDTH'(r);
    in_theta  = THETA_WIDTH'(th);
    out_ready = 1'b1;
    #1;
    check_output({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    check_output({tag, "_early"}, int'(out_valid), 0);
    tick();
    check_output({tag, "_valid"}, int'(out_valid), 1);
    check_output({tag, "_x"}, int'($signed(out_x)), ex);
    check_output({tag, "_y"}, int'($signed(out_y)), ey);
    check_output({tag, "_err"}, int'(out_err), eerr);
    tick();
  endtask

  initial begin
    bit acc;
    int n;
    int idx;
    int sr[5]  = '{10, 200, 77, 255, 128};
    int sth[5] = '{1, 7, 26, 14, 22};

    $display("[TB] starting");
    #2;
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_out_x", int'($signed(out_x)), 0);
    check_output("rst_out_y", int'($signed(out_y)), 0);
    check_output("rst_out_err", int'(out_err), 0);
    tick();
    reset_n = 1'b1;
    tick();

    directed("deg30", 200, 2, 173, 100, 0);
`ifdef P2C_ROUND_EN
    directed("deg135", 100, 9, -71, 71, 0);
`else
    directed("deg135", 100, 9, -70, 70, 0);
`endif
    directed("deg270", 255, 18, 0, -255, 0);
    directed("deg180", 255, 12, -255, 0, 0);
    directed("bad_theta", 50, 25, 0, 0, 1);
    directed("after_bad", 50, 0, 50, 0, 0);

    // Full angle sweep at full throughput, latency checked on every result.
    for (int th = 0; th < 24; th++) apply_stimulus(1, $urandom_range(0, 255), th, 1, 1, acc);
    apply_stimulus(1, 255, 31, 1, 1, acc);
    drain();

    // Stall with out_ready low: only three samples fit before in_ready drops.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      idx = (n < 5) ? n : 4;
      apply_stimulus(1, sr[idx], sth[idx], 0, 0, acc);
      if (acc) n++;
    end
    check_output("stall_accepted", n, 3);
    check_output("stall_inflight", exp_q.size(), 3);
    check_output("stall_in_ready", int'(in_ready), 0);
    check_output("stall_out_valid", int'(out_valid), 1);
    for (int i = 0; i < 20 && !(n == 5 && exp_q.size() == 0); i++) begin
      idx = (n < 5) ? n : 4;
      apply_stimulus(n < 5, sr[idx], sth[idx], 1, 0, acc);
      if (acc) n++;
    end
    check_output("stream_accepted", n, 5);
    drain();

    // Randomized traffic with random backpressure and illegal angles.
    for (int i = 0; i < 120; i++)
      apply_stimulus($urandom_range(0, 9) < 8, $urandom_range(0, 255), $urandom_range(0, 31),
                     $urandom_range(0, 9) < 7, 0, acc);
    drain();

    // Reset mid-stream with results in flight, then prove nothing stale emerges.
    apply_stimulus(1, 90, 5, 1, 0, acc);
    apply_stimulus(1, 91, 6, 1, 0, acc);
    apply_stimulus(1, 92, 7, 1, 0, acc);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_output("midrst_out_valid", int'(out_valid), 0);
    check_output("midrst_out_x", int'($signed(out_x)), 0);
    check_output("midrst_out_y", int'($signed(out_y)), 0);
    check_output("midrst_out_err", int'(out_err), 0);
    check_output("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_output("no_stale", int'(out_valid), 0);
      apply_stimulus(0, 0, 0, 1, 0, acc);
    end
    directed("post_reset", 80, 4, 40, 69, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
